// File: rtl/fifo_unpacker.sv
// Purpose: drains a wide FIFO and serializes each word into LANES narrow beats, lane 0 (LSBs) first.
// Latency: pop in cycle 0, data captured end of cycle 1, first beat valid in cycle 2; gap-free thereafter.
// Backpressure: beats hold while out_ready is low; at most two words buffered, no pop while occupancy is 2.
module fifo_unpacker #(
   parameter int DATA_WIDTH = 64,
   parameter int OUT_WIDTH  = 16,
   parameter int LANES      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_pop,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_last,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  busy
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   logic [DATA_WIDTH-1:0] cur_word_q, cur_word_d;
   logic [DATA_WIDTH-1:0] nxt_word_q, nxt_word_d;
   logic                  cur_v_q, cur_v_d;
   logic                  nxt_v_q, nxt_v_d;
   logic                  inflight_q, inflight_d;
   logic [LW-1:0]         lane_q, lane_d;
   logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

   logic [1:0] occ;
   logic       xfer;
   logic       at_last;

   // Occupancy counts the in-flight fetch so the two slots can never be oversubscribed.
   always_comb begin
      occ      = {1'b0, cur_v_q} + {1'b0, nxt_v_q} + {1'b0, inflight_q};
      fifo_pop = reset && !fifo_empty && (occ < 2'd2);
      at_last  = (lane_q == LAST_LANE);
      xfer     = cur_v_q && out_ready;
   end

   // Next-state: retire/shift the current word first, then place any arriving FIFO word.
   always_comb begin
      cur_word_d   = cur_word_q;
      nxt_word_d   = nxt_word_q;
      cur_v_d      = cur_v_q;
      nxt_v_d      = nxt_v_q;
      lane_d       = lane_q;
      word_count_d = word_count_q;
      inflight_d   = fifo_pop;

      if (xfer) begin
         if (!at_last) begin
            cur_word_d = cur_word_q >> OUT_WIDTH;
            lane_d     = lane_q + LW'(1);
         end else begin
            lane_d       = '0;
            word_count_d = word_count_q + CNT_WIDTH'(1);
            if (nxt_v_q) begin
               cur_word_d = nxt_word_q;
               cur_v_d    = 1'b1;
               nxt_v_d    = 1'b0;
            end else begin
               cur_v_d    = 1'b0;
            end
         end
      end

      // Arriving word goes to cur if it has just emptied, otherwise queues behind it.
      if (inflight_q) begin
         if (!cur_v_d) begin
            cur_word_d = fifo_data;
            cur_v_d    = 1'b1;
         end else begin
            nxt_word_d = fifo_data;
            nxt_v_d    = 1'b1;
         end
      end
   end

   // State registers; reset discards buffered and in-flight words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_word_q   <= '0;
         nxt_word_q   <= '0;
         cur_v_q      <= 1'b0;
         nxt_v_q      <= 1'b0;
         inflight_q   <= 1'b0;
         lane_q       <= '0;
         word_count_q <= '0;
      end else begin
         cur_word_q   <= cur_word_d;
         nxt_word_q   <= nxt_word_d;
         cur_v_q      <= cur_v_d;
         nxt_v_q      <= nxt_v_d;
         inflight_q   <= inflight_d;
         lane_q       <= lane_d;
         word_count_q <= word_count_d;
      end
   end

   // Outputs come straight from registered state.
   always_comb begin
      out_valid  = cur_v_q;
      out_data   = cur_word_q[OUT_WIDTH-1:0];
      out_last   = cur_v_q && at_last;
      word_count = word_count_q;
      busy       = cur_v_q | nxt_v_q | inflight_q;
   end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Purpose: directed bench for fifo_unpacker with a FIFO model and beat scoreboard.
// Latency: checks the pop-to-first-beat timing and gap-free streaming.
// Backpressure: checks beat hold, pop suppression at full occupancy, and async reset.
module tb_fifo_unpacker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [63:0] fifo_data = '0;
   logic        fifo_pop;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_last;
   logic [3:0]  word_count;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   int pops_done = 0;
   int words_done = 0;

   logic [63:0] fq[$];     // upstream FIFO contents
   logic [16:0] exp_q[$];  // expected beats: {last, data}

   fifo_unpacker #(
      .DATA_WIDTH(64), .OUT_WIDTH(16), .LANES(4), .CNT_WIDTH(4)
   ) u_dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .word_count(word_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // FIFO model: registered data_out, empty flag updated just after the edge.
   always @(posedge clk) begin
      if (fifo_pop) begin
         if (fq.size() != 0) begin
            fifo_data <= fq.pop_front();
            pops_done++;
         end
      end
      #1 fifo_empty = (fq.size() == 0);
   end

   // Monitor: pop legality and beat scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (fifo_pop) begin
         chk("pop_occ", 64'((pops_done - words_done) < 2), 64'd1);
         chk("pop_empty", 64'(fifo_empty), 64'd0);
      end
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("beat_extra", 64'd1, 64'd0);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            chk("beat_dat", 64'(out_data), 64'(e[15:0]));
            chk("beat_last", 64'(out_last), 64'(e[16]));
         end
         if (out_last) words_done++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [63:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
      for (int i = 0; i < 4; i++)
         exp_q.push_back({(i == 3), w[16*i +: 16]});
   endtask

   task automatic clear_model();
      fq.delete();
      exp_q.delete();
      pops_done  = 0;
      words_done = 0;
      fifo_empty = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      out_ready = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && fq.size() == 0 && !busy && !fifo_pop) begin
            ok = 1;
            break;
         end
      end
      chk("drain_done", 64'(ok), 64'd1);
   endtask

   initial begin
      logic [63:0] w0, w1, w2;
      int gaps;
      int cyc;
      int pushed;
      bit seen;

      // ---- reset state ----
      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pop", 64'(fifo_pop), 64'd0);
      chk("rst_cnt", 64'(word_count), 64'd0);

      // ---- single word, cycle-exact latency ----
      do_reset();
      out_ready = 1'b1;
      push_word(64'h4444_3333_2222_1111);
      @(negedge clk);  // cycle 0
      chk("lat_pop0", 64'(fifo_pop), 64'd1);
      chk("lat_valid0", 64'(out_valid), 64'd0);
      @(negedge clk);  // cycle 1
      chk("lat_valid1", 64'(out_valid), 64'd0);
      chk("lat_busy1", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         logic [15:0] ev;
         case (i)
            0: ev = 16'h1111;
            1: ev = 16'h2222;
            2: ev = 16'h3333;
            default: ev = 16'h4444;
         endcase
         @(negedge clk);  // cycles 2..5
         chk("one_valid", 64'(out_valid), 64'd1);
         chk("one_data", 64'(out_data), 64'(ev));
         chk("one_last", 64'(out_last), 64'(i == 3));
      end
      @(negedge clk);  // cycle 6
      chk("one_valid_end", 64'(out_valid), 64'd0);
      chk("one_busy_end", 64'(busy), 64'd0);
      chk("one_cnt", 64'(word_count), 64'd1);

      // ---- eight words back-to-back, gap-free ----
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) push_word({16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)});
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      chk("b2b_start", 64'(seen), 64'd1);
      gaps = 0;
      for (int i = 0; i < 32; i++) begin
         if (!out_valid) gaps++;
         if (i < 31) @(negedge clk);
      end
      chk("b2b_gaps", 64'(gaps), 64'd0);
      wait_drain(20);
      chk("b2b_cnt", 64'(word_count), 64'd8);

      // ---- backpressure with three words queued ----
      do_reset();
      w0 = 64'hA003_A002_A001_A000;
      w1 = 64'hB003_B002_B001_B000;
      w2 = 64'hC003_C002_C001_C000;
      push_word(w0);
      push_word(w1);
      push_word(w2);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_data", 64'(out_data), 64'h0000_0000_0000_A000);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_pop", 64'(fifo_pop), 64'd0);
      end
      chk("bp_pops", 64'(pops_done), 64'd2);
      step();
      out_ready = 1'b1;
      wait_drain(40);
      chk("bp_cnt", 64'(word_count), 64'd3);

      // ---- asynchronous reset mid-word ----
      do_reset();
      out_ready = 1'b1;
      push_word(64'h0D0D_0C0C_0B0B_0A0A);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid && out_data == 16'h0C0C) begin
            seen = 1;
            break;
         end
      end
      chk("mid_lane2", 64'(seen), 64'd1);
      #1 reset = 1'b0;
      #1;
      chk("mid_valid", 64'(out_valid), 64'd0);
      chk("mid_data", 64'(out_data), 64'd0);
      chk("mid_last", 64'(out_last), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_cnt", 64'(word_count), 64'd0);
      chk("mid_pop", 64'(fifo_pop), 64'd0);
      clear_model();
      out_ready = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      push_word(64'h5555_6666_7777_8888);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      chk("mid_restart", 64'(seen), 64'd1);
      chk("mid_lane0", 64'(out_data), 64'h8888);
      step();
      out_ready = 1'b1;
      wait_drain(20);
      chk("mid_cnt_after", 64'(word_count), 64'd1);

      // ---- random ready and bursty FIFO over 100 words ----
      do_reset();
      pushed = 0;
      cyc = 0;
      while (words_done < 100 && cyc < 6000) begin
         step();
         out_ready = ($urandom % 2) == 1;
         if (pushed < 100 && ($urandom % 3) != 0) begin
            push_word({$urandom, $urandom});
            pushed++;
         end
         cyc++;
      end
      chk("rnd_words", 64'(words_done), 64'd100);
      step();
      out_ready = 1'b1;
      wait_drain(20);
      chk("rnd_left", 64'(exp_q.size()), 64'd0);
      chk("rnd_cnt", 64'(word_count), 64'd4);

      // ---- word counter wrap: 17 words on a 4-bit counter ----
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 17; i++) push_word({32'hFEED_0000 | 32'(i), 32'(i * 7)});
      wait_drain(200);
      chk("wrap_cnt", 64'(word_count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fifo_unpacker.md
# fifo_unpacker

Read-side stage that drains a wide `fifo` and serializes each `DATA_WIDTH` word into `LANES` narrow beats on a valid/ready stream. It sits directly downstream of the memory-interface FIFO. It drives `pop` from the FIFO's `empty` flag and captures the FIFO's registered `data_out` one cycle later. A two-slot word buffer (current + next) hides the FIFO read latency, so the output stream runs gap-free under continuous `out_ready`.

## Interface
- `DATA_WIDTH`, 64, FIFO word width; must equal `LANES*OUT_WIDTH`
- `OUT_WIDTH`, 16, output beat width
- `LANES`, 4, beats per word; must be ≥2
- `CNT_WIDTH`, 16, width of completed-word counter
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`, valid the cycle after an accepted pop
- `fifo_pop`  out  1  pop request to FIFO (combinational)
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  OUT_WIDTH  current beat
- `out_last`  out  1  beat is the final lane of its word
- `word_count`  out  CNT_WIDTH  completed words since reset, wraps modulo 2^CNT_WIDTH
- `busy`  out  1  any slot valid or a fetch in flight

## Operation
- State: `cur_word`/`cur_v`, `nxt_word`/`nxt_v`, `inflight` (1 bit), `lane` (0..LANES-1), `word_count`.
- `occ = cur_v + nxt_v + inflight`.
- `fifo_pop = reset && !fifo_empty && occ < 2`. It is never asserted while reset is low or the FIFO is empty.
- An accepted pop sets `inflight` for the next cycle.
- When `inflight`=1, `fifo_data` is captured:
  - into `cur` if `cur` is empty after this cycle's update;
  - otherwise into `nxt`.
  - `inflight` then clears unless a new pop is also issued that cycle.
- Beat output:
  - `out_valid = cur_v`
  - `out_data = cur_word[OUT_WIDTH-1:0]`
  - `out_last = cur_v && lane==LANES-1`
- Transfer occurs when `out_valid && out_ready`:
  - Non-last lane: `cur_word` shifts right by `OUT_WIDTH` and `lane` increments. Lane 0 is the LSBs.
  - Last lane: `lane` goes to 0 and `word_count` increments. If `nxt_v`, then `cur` takes `nxt` and `nxt_v` clears; otherwise `cur_v` clears.
- Simultaneous last-lane transfer and FIFO data arrival: `nxt` (if valid) moves to `cur` and the arriving word goes to `nxt`. If `nxt` is empty, the arriving word goes directly to `cur`. No word is ever dropped or duplicated.
- `out_data`, `out_last` and `out_valid` hold stable while `out_valid && !out_ready`.
- `busy = cur_v | nxt_v | inflight`.

## Timing
- Reset (async assert, sync release) forces:
  - `cur_v`, `nxt_v`, `inflight` = 0; `lane` = 0; words = 0; `word_count` = 0
  - Resulting outputs: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `fifo_pop`=0.
- Reset mid-operation discards buffered and in-flight words. A FIFO word popped the cycle before reset is lost; the upstream FIFO is reset together with this block.
- Latency: with the FIFO non-empty and the block idle, `fifo_pop` rises in cycle 0. `fifo_data` is captured at the end of cycle 1, and `out_valid` is 1 in cycle 2.
- Throughput: with `out_ready` held high and the FIFO never empty, one beat per cycle with no bubbles (requires `LANES`≥2). The refill pop occurs the cycle after `cur` is taken from `nxt`.
- FIFO underflow: while `fifo_empty`=1, no pop is issued. `out_valid` drops after the last buffered beat.
- Backpressure: at most 2 words are held plus 0 in flight. `fifo_pop` stays 0 while `occ`=2.
- `word_count` wraps from 2^CNT_WIDTH−1 to 0 without a flag.

## Test plan
- Reset then push one word 0x4444_3333_2222_1111 into the FIFO, `out_ready`=1 → beats 0x1111, 0x2222, 0x3333, 0x4444 on cycles 2–5; `out_last` only on 0x4444; `word_count`=1; `busy`=0 after.
- 8 words back-to-back, `out_ready`=1 → 32 consecutive beats with `out_valid` never deasserting after the first; `word_count`=8.
- Random `out_ready` (50%) over 100 words → beat sequence matches the reference unpack; `fifo_pop` never asserted with `occ`=2 or `fifo_empty`=1.
- `out_ready`=0 with 3 words queued → exactly 2 pops, then `fifo_pop`=0; `out_data`=low lane of word 0 held stable; releasing `out_ready` drains all 3 in order.
- Assert `reset` low mid-word (lane 2) → all outputs 0 immediately (asynchronous); after release with a freshly reset FIFO, the next word starts at lane 0.
- `CNT_WIDTH`=4, 17 words → `word_count` reads 1 at the end (wrap verified).
